// File: rtl/aes_bist_pkg.sv
// ============================================================================
// Module      : aes_bist_pkg
// Description : Shared state encoding, counter width and default run constants
//               for the AES BIST controller.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package aes_bist_pkg;

    localparam int          CNT_W          = 8;
    localparam int          C_NUM_PATTERNS = 16;
    localparam int          C_PIPE_LAT     = 4;
    localparam logic [7:0]  C_GOLDEN_SIG   = 8'hC0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/aes_bist_cnt.sv
// ============================================================================
// Module      : aes_bist_cnt
// Description : Loadable phase down-counter; holds at zero instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module aes_bist_cnt
    import aes_bist_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/aes_bist_ctrl.sv
// ============================================================================
// Module      : aes_bist_ctrl
// Description : BIST sequencer for the AES core: clear, LFSR stimulus, pipeline
//               drain, MISR signature check. Optional signature capture is
//               enabled with the AES_BIST_SIG_CAPTURE_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module aes_bist_ctrl
    import aes_bist_pkg::*;
#(
    parameter int         NUM_PATTERNS = C_NUM_PATTERNS,
    parameter int         PIPE_LAT     = C_PIPE_LAT,
    parameter logic [7:0] GOLDEN_SIG   = C_GOLDEN_SIG
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] misr_sig,
    output logic       lfsr_misr_en,
    output logic       bist_mode,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] sig_out
);

    // Counter is loaded with phase length minus one so zero marks the last cycle.
    localparam logic [CNT_W-1:0] C_RUN_LOAD   = CNT_W'(NUM_PATTERNS - 1);
    localparam logic [CNT_W-1:0] C_DRAIN_LOAD = (PIPE_LAT > 0) ? CNT_W'(PIPE_LAT - 1) : '0;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_val;
    logic             w_cnt_dec;
    logic             w_cnt_zero;
    logic             w_check_done;
    logic             r_done;
    logic             r_pass;

    aes_bist_cnt u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_load   = 1'b0;
        w_cnt_val    = '0;
        w_cnt_dec    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_RUN;
                    w_cnt_load   = 1'b1;
                    w_cnt_val    = C_RUN_LOAD;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_cnt_zero) begin
                    if (PIPE_LAT == 0) begin
                        w_state_next = ST_CHECK;
                    end else begin
                        w_state_next = ST_DRAIN;
                        w_cnt_load   = 1'b1;
                        w_cnt_val    = C_DRAIN_LOAD;
                    end
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_cnt_zero) begin
                    w_state_next = ST_CHECK;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_CHECK: begin
                w_state_next = abort ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                if (start) w_state_next = ST_CLEAR;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_check_done = (r_state == ST_CHECK) && (w_state_next == ST_DONE);

    // Pass survives only while staying in DONE; any other next state clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else begin
            r_done <= w_check_done;
            if (w_check_done) begin
                r_pass <= (misr_sig == GOLDEN_SIG);
            end else if (w_state_next != ST_DONE) begin
                r_pass <= 1'b0;
            end
        end
    end

`ifdef AES_BIST_SIG_CAPTURE_EN
    logic [7:0] r_sig;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= 8'h00;
        end else if (w_state_next == ST_CLEAR) begin
            r_sig <= 8'h00;
        end else if (w_check_done) begin
            r_sig <= misr_sig;
        end
    end

    assign sig_out = r_sig;
`else
    assign sig_out = 8'h00;
`endif

    assign lfsr_misr_en = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign busy         = (r_state == ST_CLEAR) || (r_state == ST_RUN) ||
                          (r_state == ST_DRAIN) || (r_state == ST_CHECK);
    assign bist_mode    = (r_state != ST_IDLE);
    assign done         = r_done;
    assign pass         = r_pass;

endmodule

`default_nettype wire

// File: tb/tb_aes_bist_ctrl.sv
// ============================================================================
// Module      : tb_aes_bist_ctrl
// Description : Directed self-checking bench for aes_bist_ctrl (default build
//               and a NUM_PATTERNS=1 / PIPE_LAT=0 instance).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_aes_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort;
    logic [7:0] misr_sig;
    logic       en, bm, busy, done, pass;
    logic [7:0] sig;

    logic       start0, abort0;
    logic [7:0] misr0;
    logic       en0, bm0, busy0, done0, pass0;
    logic [7:0] sig0;

    logic       sel;
    int         n_total = 0;
    int         n_pass  = 0;

    logic [7:0] exp_sig_c0, exp_sig_c1;

    always #5 clk = ~clk;

    aes_bist_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .misr_sig(misr_sig),
        .lfsr_misr_en(en), .bist_mode(bm), .busy(busy), .done(done),
        .pass(pass), .sig_out(sig)
    );

    aes_bist_ctrl #(.NUM_PATTERNS(1), .PIPE_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .misr_sig(misr0),
        .lfsr_misr_en(en0), .bist_mode(bm0), .busy(busy0), .done(done0),
        .pass(pass0), .sig_out(sig0)
    );

    wire       m_en   = sel ? en0   : en;
    wire       m_busy = sel ? busy0 : busy;
    wire       m_done = sel ? done0 : done;
    wire       m_pass = sel ? pass0 : pass;
    wire [7:0] m_sig  = sel ? sig0  : sig;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Launch one run and sample every cycle until the controller settles in DONE/IDLE.
    task automatic run(input logic use0, input logic [7:0] s,
                       output int en_c, output int busy_c, output int done_c,
                       output logic pass_v, output logic [7:0] sig_v);
        en_c = 0; busy_c = 0; done_c = 0; pass_v = 1'b0; sig_v = 8'h00;
        sel = use0;
        if (use0) begin start0 = 1'b1; misr0 = s; end
        else      begin start  = 1'b1; misr_sig = s; end
        step();
        start = 1'b0; start0 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (m_en)   en_c++;
            if (m_busy) busy_c++;
            if (m_done) begin done_c++; pass_v = m_pass; sig_v = m_sig; end
            if (!m_busy && !m_done) break;
            step();
        end
    endtask

    int         e_c, b_c, d_c;
    logic       p_v;
    logic [7:0] s_v;

    initial begin
`ifdef AES_BIST_SIG_CAPTURE_EN
        exp_sig_c0 = 8'hC0; exp_sig_c1 = 8'hC1;
`else
        exp_sig_c0 = 8'h00; exp_sig_c1 = 8'h00;
`endif
        rst = 1'b0; start = 1'b0; abort = 1'b0; misr_sig = 8'h00;
        start0 = 1'b0; abort0 = 1'b0; misr0 = 8'h00; sel = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_en", en, 0);   chk("rst_bm", bm, 0);     chk("rst_busy", busy, 0);
        chk("rst_done", done, 0); chk("rst_pass", pass, 0); chk("rst_sig", sig, 0);
        chk("rst_busy0", busy0, 0);
        step(); step();
        rst = 1'b0;
        step();

        // default run, matching signature
        run(1'b0, 8'hC0, e_c, b_c, d_c, p_v, s_v);
        chk("run1_en_cycles", e_c, 20);  chk("run1_busy_cycles", b_c, 22);
        chk("run1_done_pulses", d_c, 1); chk("run1_pass", p_v, 1);
        chk("run1_sig", s_v, exp_sig_c0);
        chk("run1_pass_hold", pass, 1);  chk("run1_bm_done", bm, 1);

        // abort in DONE is ignored
        abort = 1'b1; step(); abort = 1'b0;
        chk("done_abort_pass", pass, 1); chk("done_abort_bm", bm, 1);
        chk("done_abort_busy", busy, 0);

        // mismatching signature
        run(1'b0, 8'hC1, e_c, b_c, d_c, p_v, s_v);
        chk("run2_en_cycles", e_c, 20); chk("run2_done_pulses", d_c, 1);
        chk("run2_pass", p_v, 0);       chk("run2_sig", s_v, exp_sig_c1);

        // abort in RUN cycle 5
        start = 1'b1; misr_sig = 8'hC0; step(); start = 1'b0;
        repeat (5) step();
        chk("ab_run_en", en, 1);
        abort = 1'b1; step(); abort = 1'b0;
        chk("ab_en", en, 0); chk("ab_bm", bm, 0); chk("ab_busy", busy, 0);
        chk("ab_done", done, 0); chk("ab_pass", pass, 0);
        step();
        chk("ab_done_later", done, 0);
        run(1'b0, 8'hC0, e_c, b_c, d_c, p_v, s_v);
        chk("rerun_en_cycles", e_c, 20); chk("rerun_done_pulses", d_c, 1);
        chk("rerun_pass", p_v, 1);

        // NUM_PATTERNS=1, PIPE_LAT=0 instance
        run(1'b1, 8'hC0, e_c, b_c, d_c, p_v, s_v);
        chk("p0_en_cycles", e_c, 1);    chk("p0_busy_cycles", b_c, 3);
        chk("p0_done_pulses", d_c, 1);  chk("p0_pass", p_v, 1);
        sel = 1'b0;

        // start held in DONE restarts; start+abort in RUN aborts
        start = 1'b1; step();
        chk("restart_busy", busy, 1); chk("restart_pass", pass, 0);
        chk("restart_en", en, 0);     chk("restart_bm", bm, 1);
        step();
        chk("restart_run_en", en, 1);
        abort = 1'b1; step(); abort = 1'b0;
        chk("sa_busy", busy, 0); chk("sa_en", en, 0); chk("sa_bm", bm, 0);
        step();
        chk("idle_start_busy", busy, 1);
        start = 1'b0;

        // reset asserted mid-DRAIN (second DRAIN cycle)
        repeat (18) step();
        chk("drain_en", en, 1); chk("drain_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_en", en, 0);     chk("arst_bm", bm, 0);   chk("arst_busy", busy, 0);
        chk("arst_done", done, 0); chk("arst_pass", pass, 0); chk("arst_sig", sig, 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_busy", busy, 0); chk("post_rst_bm", bm, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_bist_ctrl.md
AES_BIST_CTRL -- requirements
Module: aes_bist_ctrl

Interface
REQ-001 SHALL have parameter NUM_PATTERNS, default 16: number of LFSR stimulus cycles per run, legal range 1..255.
REQ-002 SHALL have parameter PIPE_LAT, default 4: cycles from stimulus to core output, legal range 0..63.
REQ-003 SHALL have parameter GOLDEN_SIG, default 8'hC0: expected MISR signature.
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: run request, sampled only in IDLE or DONE.
REQ-007 SHALL have port abort, input, 1: synchronous cancel of an active run.
REQ-008 SHALL have port misr_sig, input, 8: signature from the LFSR/MISR wrapper.
REQ-009 SHALL have port lfsr_misr_en, output, 1: enable to the wrapper's LFSRs and MISR.
REQ-010 SHALL have port bist_mode, output, 1: steers the core's key/data muxes to LFSR sources.
REQ-011 SHALL have port busy, output, 1: high in CLEAR, RUN, DRAIN and CHECK.
REQ-012 SHALL have port done, output, 1: one-cycle pulse on entry to DONE.
REQ-013 SHALL have port pass, output, 1: registered result; valid while in DONE.
REQ-014 SHALL have port sig_out, output, 8: captured signature (see REQ-027).

Function
REQ-015 SHALL implement FSM states IDLE, CLEAR, RUN, DRAIN, CHECK, DONE.
REQ-016 SHALL go IDLE->CLEAR on start=1; CLEAR lasts exactly 1 cycle with bist_mode=1 and lfsr_misr_en=0.
REQ-017 SHALL assert lfsr_misr_en in RUN for exactly NUM_PATTERNS cycles, then in DRAIN for exactly PIPE_LAT cycles, for NUM_PATTERNS+PIPE_LAT consecutive enabled cycles.
REQ-018 SHALL go RUN->CHECK directly (no DRAIN cycle) when PIPE_LAT=0.
REQ-019 SHALL hold lfsr_misr_en=0 in CHECK; CHECK lasts 1 cycle and registers pass = (misr_sig == GOLDEN_SIG).
REQ-020 SHALL go CHECK->DONE, pulse done for 1 cycle, and hold pass until the next start.
REQ-021 SHALL go DONE->CLEAR on start=1 (pass cleared to 0 on that edge); otherwise remain in DONE.
REQ-022 SHALL, on abort=1 in CLEAR, RUN, DRAIN or CHECK, go to IDLE next cycle with lfsr_misr_en=0, bist_mode=0, pass=0 and no done pulse.
REQ-023 SHALL give abort priority over start in the same cycle; abort in IDLE or DONE has no effect.
REQ-024 SHALL use an 8-bit cycle counter loaded on each phase entry; the counter must never wrap within a phase.
REQ-025 SHALL drive bist_mode=1 from CLEAR through DONE, and 0 in IDLE.

Reset
REQ-026 SHALL, while rst=1, force state=IDLE, counter=0, lfsr_misr_en=0, bist_mode=0, busy=0, done=0, pass=0 and sig_out=8'h00, asynchronously; reset during any state discards the run.

Configuration
REQ-027 SHALL, with AES_BIST_SIG_CAPTURE_EN defined, register misr_sig into sig_out in CHECK and hold it until the next CLEAR, which sets it to 0. Without the macro, sig_out SHALL be constant 8'h00 and no capture register SHALL exist.

Structure
REQ-028 SHALL take the state enum, default constants (16, 4, 8'hC0) and counter width from shared package aes_bist_pkg.
REQ-029 SHALL place the loadable down-counter (load, dec, zero flag) in sub-module aes_bist_cnt.

Verification
REQ-030 SHALL cover the default run, stimulus start pulse with misr_sig=8'hC0 in CHECK: lfsr_misr_en high for exactly 20 cycles, done 1 cycle, pass=1, sig_out=8'hC0 if the macro is defined.
REQ-031 SHALL cover a signature mismatch, misr_sig=8'hC1 in CHECK: pass=0 and done pulses.
REQ-032 SHALL cover abort in RUN cycle 5: IDLE next cycle, enable low, no done, then a full rerun passes.
REQ-033 SHALL cover PIPE_LAT=0 with NUM_PATTERNS=1: exactly 1 enabled cycle, DRAIN never entered.
REQ-034 SHALL cover rst asserted mid-DRAIN: all outputs 0 immediately, state IDLE.
REQ-035 SHALL cover start and abort together in RUN, plus start held in DONE: abort wins; in DONE a new run begins.
